prebuf_pingpong_ctrl: RTL

Ping-pong line-buffer controller placed directly upstream of the pre-buffer dual-port BRAM (2 × LINE_W words). It accepts a valid/ready pixel stream, writes each line into one BRAM half over port 0, and simultaneously streams the previously completed line out of the other half over port 1. Its output is a valid/ready stream with end-of-line marking, feeding the downstream filter stage.

---
 rtl/prebuf_pkg.sv | 16 +
 rtl/prebuf_pingpong_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/prebuf_pkg.sv
// rtl/prebuf_pkg.sv - shared types and constants for the pre-buffer ping-pong controller
package prebuf_pkg;

  typedef logic bank_t;

  localparam int DEF_LINE_W = 1920;

  // Bank 1 starts right after one full line of bank 0.
  localparam int BANK1_BASE = DEF_LINE_W;

  // Counter wide enough to hold a full line length (0..line_w).
  function automatic int cnt_w(input int line_w);
    return $clog2(line_w + 1);
  endfunction

endpackage

// File: rtl/prebuf_pingpong_ctrl.sv
// rtl/prebuf_pingpong_ctrl.sv - ping-pong line buffer controller in front of the pre-buffer BRAM
module prebuf_pingpong_ctrl
  import prebuf_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12,
  parameter int LINE_W = BANK1_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWIDTH-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  output logic [AWIDTH-1:0] ram_addr0,
  output logic              ram_ce0,
  output logic              ram_we0,
  output logic [DWIDTH-1:0] ram_d0,
  output logic [AWIDTH-1:0] ram_addr1,
  output logic              ram_ce1,
  output logic              ram_we1,
  input  logic [DWIDTH-1:0] ram_q1,
  output logic              line_err,
  output logic [1:0]        lines_stored
);

  localparam int CW = cnt_w(LINE_W);
  localparam logic [CW-1:0]     LAST_IDX = CW'(LINE_W - 1);
  localparam logic [AWIDTH-1:0] B1_ADDR  = AWIDTH'(LINE_W);

  logic [1:0]    full;
  bank_t         wr_bank;
  bank_t         rd_bank;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] len [2];
  logic          wr_accept;
  logic          wr_close;
  logic          issue;
  logic          rd_close;

  // Port strobes, addresses and handshake terms derived from the current bank state.
  always_comb begin
    s_ready      = rst_n && !full[wr_bank];
    wr_accept    = s_valid && s_ready;
    wr_close     = wr_accept && (s_last || (wr_cnt == LAST_IDX));
    ram_ce0      = wr_accept;
    ram_we0      = wr_accept;
    ram_addr0    = (wr_bank ? B1_ADDR : '0) + AWIDTH'(wr_cnt);
    ram_d0       = rst_n ? s_data : '0;
    issue        = rst_n && full[rd_bank] && (!m_valid || m_ready);
    rd_close     = issue && (rd_cnt == len[rd_bank] - CW'(1));
    ram_ce1      = issue;
    ram_we1      = 1'b0;
    ram_addr1    = (rd_bank ? B1_ADDR : '0) + AWIDTH'(rd_cnt);
    m_data       = ram_q1;
    lines_stored = {1'b0, full[0]} + {1'b0, full[1]};
  end

  // Write side: count accepted pixels, close the line on s_last or a full line, flag length mismatch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt   <= '0;
      wr_bank  <= 1'b0;
      line_err <= 1'b0;
      len[0]   <= '0;
      len[1]   <= '0;
    end else if (wr_accept) begin
      if (wr_close) begin
        len[wr_bank] <= wr_cnt + CW'(1);
        wr_bank      <= !wr_bank;
        wr_cnt       <= '0;
      end else begin
        wr_cnt <= wr_cnt + CW'(1);
      end
      if (s_last != (wr_cnt == LAST_IDX)) begin
        line_err <= 1'b1;
      end
    end
  end

  // Read side: issue one read per free output slot; the BRAM's one-cycle latency lines up with m_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (issue) begin
      m_valid <= 1'b1;
      m_last  <= rd_close;
      if (rd_close) begin
        rd_cnt  <= '0;
        rd_bank <= !rd_bank;
      end else begin
        rd_cnt <= rd_cnt + CW'(1);
      end
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Bank occupancy: the writer fills one bank while the reader frees the other, never the same one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 2'b00;
    end else begin
      if (wr_close) full[wr_bank] <= 1'b1;
      if (rd_close) full[rd_bank] <= 1'b0;
    end
  end

endmodule
